// File: rtl/pi_pkg.sv
// Shared definitions for the PI flag controller: flag write modes and the
// level-to-request one-hot helper.
package pi_pkg;

  localparam logic [1:0] FM_LOAD = 2'b00;
  localparam logic [1:0] FM_SET  = 2'b01;
  localparam logic [1:0] FM_CLR  = 2'b10;
  localparam logic [1:0] FM_NOP  = 2'b11;

  // Level k maps to bit k-1; level 0 and levels beyond nLevels request nothing.
  function automatic logic [31:0] onehot_lvl(input logic [31:0] lvl, input logic [31:0] nLevels);
    logic [31:0] oneHot;
    oneHot = 32'd0;
    if ((lvl != 32'd0) && (lvl <= nLevels)) begin
      oneHot = 32'd1 << (lvl - 32'd1);
    end else begin
      oneHot = 32'd0;
    end
    return oneHot;
  endfunction

endpackage

// File: rtl/pi_prio_enc.sv
// Combinational lowest-index priority encoder; the parent registers idx/vld.
module pi_prio_enc #(
  parameter  int NFLAGS = 8,
  localparam int IW     = (NFLAGS > 1) ? $clog2(NFLAGS) : 1
) (
  input  logic [NFLAGS-1:0] req,
  output logic [IW-1:0]     idx,
  output logic              vld
);

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    idx = {IW{1'b0}};
    vld = |req;
    for (int i = NFLAGS - 1; i >= 0; i--) begin
      idx = req[i] ? IW'(i) : idx;
    end
  end

endmodule

// File: rtl/pi_flag_ctl.sv
// Sticky interrupt flags with enable mask, rising-edge capture independent of
// clken, software load/set/clear, registered PI request and source reporting.
module pi_flag_ctl
  import pi_pkg::*;
#(
  parameter  int NFLAGS  = 8,
  parameter  int NLEVELS = 7,
  localparam int LW      = $clog2(NLEVELS + 1),
  localparam int IW      = (NFLAGS > 1) ? $clog2(NFLAGS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clken,
  input  logic [NFLAGS-1:0]  int_in,
  input  logic               flag_wr,
  input  logic [1:0]         flag_mode,
  input  logic [NFLAGS-1:0]  flag_data,
  input  logic               cfg_wr,
  input  logic [NFLAGS-1:0]  cfg_en,
  input  logic [NFLAGS-1:0]  cfg_auto,
  input  logic               cfg_sw,
  input  logic [LW-1:0]      cfg_lvl,
  input  logic               pi_ack,
  output logic [NFLAGS-1:0]  flags,
  output logic [NFLAGS-1:0]  en_mask,
  output logic               int_req,
  output logic [IW-1:0]      src_idx,
  output logic               src_vld,
  output logic [NLEVELS-1:0] pi_req_out
);

  logic [NFLAGS-1:0]  intPrev;
  logic [NFLAGS-1:0]  flagsReg;
  logic [NFLAGS-1:0]  enReg;
  logic [NFLAGS-1:0]  autoReg;
  logic               swReg;
  logic [LW-1:0]      lvlReg;
  logic               intReqReg;
  logic [IW-1:0]      srcIdxReg;
  logic               srcVldReg;
  logic [NLEVELS-1:0] piReqReg;

  logic [NFLAGS-1:0]  edgeDet;
  logic               swWrite;
  logic               cfgWrite;
  logic [NFLAGS-1:0]  swData;
  logic [NFLAGS-1:0]  ackClr;
  logic [NFLAGS-1:0]  flagsNext;
  logic [NFLAGS-1:0]  pending;
  logic [IW-1:0]      encIdx;
  logic               encVld;
  logic               intReqNext;
  logic [NLEVELS-1:0] piReqNext;

  assign edgeDet  = int_in & ~intPrev;
  assign swWrite  = clken & flag_wr;
  assign cfgWrite = clken & cfg_wr;
  assign pending  = flagsReg & enReg;

  // Edge-detect history runs every clock so short pulses are never missed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      intPrev <= {NFLAGS{1'b0}};
    end else begin
      intPrev <= int_in;
    end
  end

  // Software write data for the selected mode.
  always_comb begin
    swData = flagsReg;
    case (flag_mode)
      FM_LOAD: swData = flag_data;
      FM_SET:  swData = flagsReg | flag_data;
      FM_CLR:  swData = flagsReg & ~flag_data;
      FM_NOP:  swData = flagsReg;
      default: swData = flagsReg;
    endcase
  end

  // Ack targets the registered source of this cycle, only where auto-clear is on.
  always_comb begin
    ackClr = {NFLAGS{1'b0}};
    for (int i = 0; i < NFLAGS; i++) begin
      ackClr[i] = pi_ack & srcVldReg & autoReg[i] & (srcIdxReg == IW'(i));
    end
  end

  // Per-bit priority: hardware edge, then software write, then ack clear.
  always_comb begin
    flagsNext = flagsReg;
    for (int i = 0; i < NFLAGS; i++) begin
      if (edgeDet[i]) begin
        flagsNext[i] = 1'b1;
      end else if (swWrite) begin
        flagsNext[i] = swData[i];
      end else if (ackClr[i]) begin
        flagsNext[i] = 1'b0;
      end else begin
        flagsNext[i] = flagsReg[i];
      end
    end
  end

  // Flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flagsReg <= {NFLAGS{1'b0}};
    end else begin
      flagsReg <= flagsNext;
    end
  end

  // Configuration loads as one unit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enReg   <= {NFLAGS{1'b0}};
      autoReg <= {NFLAGS{1'b0}};
      swReg   <= 1'b0;
      lvlReg  <= {LW{1'b0}};
    end else if (cfgWrite) begin
      enReg   <= cfg_en;
      autoReg <= cfg_auto;
      swReg   <= cfg_sw;
      lvlReg  <= cfg_lvl;
    end else begin
      enReg   <= enReg;
      autoReg <= autoReg;
      swReg   <= swReg;
      lvlReg  <= lvlReg;
    end
  end

  pi_prio_enc #(
    .NFLAGS (NFLAGS)
  ) uPrioEnc (
    .req (pending),
    .idx (encIdx),
    .vld (encVld)
  );

  // Request terms derived from the current registers.
  always_comb begin
    intReqNext = encVld | swReg;
    if (intReqNext) begin
      piReqNext = NLEVELS'(onehot_lvl(32'(lvlReg), NLEVELS));
    end else begin
      piReqNext = {NLEVELS{1'b0}};
    end
  end

  // Output registers trail the flag/config registers by one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      intReqReg <= 1'b0;
      srcIdxReg <= {IW{1'b0}};
      srcVldReg <= 1'b0;
      piReqReg  <= {NLEVELS{1'b0}};
    end else begin
      intReqReg <= intReqNext;
      srcIdxReg <= encIdx;
      srcVldReg <= encVld;
      piReqReg  <= piReqNext;
    end
  end

  assign flags      = flagsReg;
  assign en_mask    = enReg;
  assign int_req    = intReqReg;
  assign src_idx    = srcIdxReg;
  assign src_vld    = srcVldReg;
  assign pi_req_out = piReqReg;

endmodule

// File: doc/pi_flag_ctl.md
# pi_flag_ctl

Parametrised successor to the fixed 8-flag APR interrupt logic. Holds NFLAGS sticky interrupt flags and a matching enable mask, and sets flags on rising edges of hardware interrupt inputs independent of clken, so short pulses are never lost. Software can load, set or clear the flags. It drives a registered one-hot PI request on a programmable level and reports the highest-priority pending source. An acknowledge handshake optionally auto-clears that source. It sits beside the microcode datapath and feeds the bus PI request lines.

## Interface
Parameters:
- NFLAGS, 8, number of interrupt flags (1..32)
- NLEVELS, 7, number of PI levels (1..7)
- LW, $clog2(NLEVELS+1), level field width (derived)
- IW, $clog2(NFLAGS), source index width (derived, minimum 1)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- clken  in  1  microcode clock enable; gates all software writes
- int_in  in  NFLAGS  synchronous hardware interrupt inputs; rising edge sets the flag
- flag_wr  in  1  flag write strobe (qualified by clken)
- flag_mode  in  2  00 load, 01 set (OR), 10 clear (AND-NOT), 11 no-op
- flag_data  in  NFLAGS  flag write data
- cfg_wr  in  1  config write strobe (qualified by clken)
- cfg_en  in  NFLAGS  enable mask data
- cfg_auto  in  NFLAGS  auto-clear-on-ack mask data
- cfg_sw  in  1  software interrupt bit
- cfg_lvl  in  LW  PI level, 0 = disabled
- pi_ack  in  1  one-cycle acknowledge of the current source
- flags  out  NFLAGS  current flag register
- en_mask  out  NFLAGS  current enable register
- int_req  out  1  any enabled flag set, or sw set (registered)
- src_idx  out  IW  lowest-numbered enabled pending flag (registered)
- src_vld  out  1  src_idx is valid (registered)
- pi_req_out  out  NLEVELS  one-hot request; bit k-1 = level k (registered)

## Operation
- Edge detect: the int_prev register samples int_in every clk, not gated by clken.
  - edge = int_in & ~int_prev.
- Flag next-state per bit i, in priority order:
  1. edge[i] → 1.
  2. Software write when clken&flag_wr applies flag_mode to flag_data[i].
  3. Otherwise, pi_ack&src_vld&(src_idx==i)&auto[i] → 0.
  4. Otherwise, hold.
- Hardware edge beats software clear/load and ack on the same bit in the same cycle.
- Software write beats ack on the same bit.
- Config: clken&cfg_wr loads en, auto, sw and lvl together.
- pending = flags & en.
- int_req = |pending | sw.
- src_vld = |pending. src_idx = lowest set index of pending, 0 when none. sw does not produce a src_vld.
- pi_req_out = int_req && lvl≠0 ? one-hot(lvl) : 0. A lvl above NLEVELS yields 0.
- pi_ack with src_vld=0, or with auto[src_idx]=0, has no effect on flags.

## Timing
- Reset: flags, en, auto, sw, lvl and int_prev are 0. int_req, src_vld, src_idx and pi_req_out are 0.
  - int_prev=0 at reset, so an int_in held high through reset sets its flag on the first clk after deassertion.
- int_in rise at edge N → flags[i]=1 after edge N → int_req/src/pi_req_out updated after edge N+1. The flag-to-request latency is 1 cycle.
- Software writes follow the same pattern: the register updates at the write edge, and the outputs follow one edge later.
- pi_ack is sampled against the registered src_idx of the same cycle. The cleared flag is visible the next cycle, and src_idx advances one cycle after that.
- A pulse held high for several cycles sets the flag once. Software can clear it while int_in stays high; it does not re-set until the next rising edge.
- clken low blocks all writes but does not block edge capture or output updates.

## Structure
- Package pi_pkg holds:
  - flag_mode constants: FM_LOAD, FM_SET, FM_CLR, FM_NOP.
  - A function onehot_lvl(lvl, NLEVELS).
- One sub-module, pi_prio_enc, parametrised NFLAGS. It is a combinational lowest-index priority encoder producing idx and vld; its outputs are registered in the parent.
- Everything else is flat in pi_flag_ctl. Budget is about 200 lines.

## Test plan
Defaults NFLAGS=8, NLEVELS=7.
- Reset, then a 1-cycle int_in=8'h04 with en=8'h04, lvl=3 → flags=8'h04, and 1 cycle later int_req=1, src_idx=2, pi_req_out=7'b0000100.
- flag_mode sequence: load 8'hA5, then set 8'h0A, then clear 8'h21, with clken=1 → flags=8'hA5, then 8'hAF, then 8'h8E. Repeating with clken=0 leaves flags unchanged.
- Simultaneous int_in rise on bit 3 and clear 8'h08 → flags[3]=1.
- Pending 8'h12 with en=8'hFF, auto=8'hFF, lvl=7 → src_idx=1.
  - pi_ack → flags=8'h10, and src_idx=4 two cycles after the ack.
  - pi_ack again → flags=0, int_req=0, pi_req_out=0.
- sw=1 with en=0 and lvl=1 → int_req=1, src_vld=0, pi_req_out=7'b0000001. Setting lvl=0 → pi_req_out=0 while int_req stays 1.
- Assert rst while flags=8'hFF and int_in is held at 8'h01 → all outputs 0 immediately. After release, flags=8'h01 on the first edge.
